// File: rtl/car_signal_ctrl_if.sv
// Switch/brake inputs and lamp/mode/tick outputs of the car signal controller.
interface car_signal_ctrl_if #(
  parameter int unsigned LAMPS = 3
);
  logic [3:0]       sw;
  logic             brake;
  logic [LAMPS-1:0] left_lamp;
  logic [LAMPS-1:0] right_lamp;
  logic [2:0]       mode;
  logic             tick;

  modport master (output sw, brake, input left_lamp, right_lamp, mode, tick);
  modport slave  (input sw, brake, output left_lamp, right_lamp, mode, tick);
endinterface

// File: rtl/car_signal_ctrl.sv
// Car lamp controller: N-lamp sequential turn sweep, unison hazard flash and brake override.
// Inputs are synchronised (sw also debounced); blink rate comes from an internal tick counter.
module car_signal_ctrl #(
  parameter int unsigned LAMPS       = 3,
  parameter int unsigned HALF_PERIOD = 6000000,
  parameter int unsigned DB_CYCLES   = 240000
) (
  input logic              clk,
  input logic              rst,
  car_signal_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned PH_W  = (LAMPS + 1 > 1) ? $clog2(LAMPS + 1) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [PH_W-1:0]  SWEEP_LAST = PH_W'(LAMPS);

  typedef enum logic [2:0] {
    MODE_IDLE     = 3'd0,
    MODE_STRAIGHT = 3'd1,
    MODE_LEFT     = 3'd2,
    MODE_RIGHT    = 3'd3,
    MODE_HAZARD   = 3'd4
  } mode_e;

  logic [3:0]      sw_meta, sw_sync, sw_cand, sw_db;
  logic            brake_meta, brake_sync;
  logic [DB_W-1:0] db_cnt;

  mode_e            mode_q, mode_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;
  logic [LAMPS-1:0] left_q, left_d, right_q, right_d;
  logic [LAMPS-1:0] sweep, brake_pat;
  logic             tick_now;

  function automatic mode_e decode_sw(logic [3:0] s);
    case (s)
      4'b0110: return MODE_STRAIGHT;
      4'b1000: return MODE_LEFT;
      4'b0001: return MODE_RIGHT;
      4'b1111: return MODE_HAZARD;
      default: return MODE_IDLE;
    endcase
  endfunction

  // Two-flop synchronisers and a stability counter that holds once the value is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      sw_cand    <= '0;
      sw_db      <= '0;
      db_cnt     <= '0;
      brake_meta <= 1'b0;
      brake_sync <= 1'b0;
    end else begin
      sw_meta    <= bus.sw;
      sw_sync    <= sw_meta;
      brake_meta <= bus.brake;
      brake_sync <= brake_meta;
      if (sw_sync != sw_cand) begin
        sw_cand <= sw_sync;
        db_cnt  <= '0;
      end else if (db_cnt == DB_LAST) begin
        sw_db <= sw_cand;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_IDLE;
      phase_q    <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      left_q     <= '1;
      right_q    <= '1;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  always_comb begin
    mode_d     = decode_sw(sw_db);
    tick_now   = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_now ? '0 : tick_cnt_q + CNT_W'(1);
    phase_d    = phase_q;
    left_d     = '1;
    right_d    = '1;

    // A mode change restarts the pattern and beats a coincident tick
    if (mode_d != mode_q) begin
      tick_cnt_d = '0;
      phase_d    = '0;
    end else begin
      case (mode_q)
        MODE_LEFT, MODE_RIGHT:
          if (tick_now) phase_d = (phase_q == SWEEP_LAST) ? '0 : phase_q + PH_W'(1);
        MODE_HAZARD:
          if (tick_now) phase_d = PH_W'(phase_q == '0);
        default:
          phase_d = '0;
      endcase
    end
    tick_d = (tick_cnt_d == TICK_LAST);

    // Active-low lamps: lamps 0..phase lit, all dark at the final phase
    for (int unsigned i = 0; i < LAMPS; i++) begin
      sweep[i] = !((phase_q < SWEEP_LAST) && (PH_W'(i) <= phase_q));
    end
    brake_pat = {LAMPS{~brake_sync}};

    case (mode_q)
      MODE_LEFT: begin
        left_d  = sweep;
        right_d = brake_pat;
      end
      MODE_RIGHT: begin
        left_d  = brake_pat;
        right_d = sweep;
      end
      MODE_HAZARD: begin
        left_d  = {LAMPS{phase_q[0]}};
        right_d = {LAMPS{phase_q[0]}};
      end
      default: begin
        left_d  = brake_pat;
        right_d = brake_pat;
      end
    endcase
  end

  assign bus.mode       = mode_q;
  assign bus.tick       = tick_q;
  assign bus.left_lamp  = left_q;
  assign bus.right_lamp = right_q;
endmodule

// File: tb/tb_car_signal_ctrl.sv
// Self-checking bench for car_signal_ctrl against a time-stamp based behavioural model.
module tb_car_signal_ctrl;
  localparam int unsigned L  = 3;
  localparam int unsigned HP = 4;
  localparam int unsigned DB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  car_signal_ctrl_if #(.LAMPS(L)) bus ();

  car_signal_ctrl #(.LAMPS(L), .HALF_PERIOD(HP), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: inputs delayed through queues; tick/phase derived from cycles since last mode change
  int         n = 0, epoch = 0, m_run = 0, m_phase = 0;
  logic [3:0] m_cand = '0, m_db = '0;
  logic [2:0] m_mode = '0;
  logic [3:0] swh[$];
  logic       bh[$];
  logic [L-1:0] exp_left = '1, exp_right = '1;
  logic [2:0]   exp_mode = '0;
  logic         exp_tick = 1'b0;

  function automatic logic [2:0] decode(logic [3:0] s);
    case (s)
      4'b0110: return 3'd1;
      4'b1000: return 3'd2;
      4'b0001: return 3'd3;
      4'b1111: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [L-1:0] sweep_pat(int ph);
    int lit;
    lit = (ph < int'(L)) ? (1 << (ph + 1)) - 1 : 0;
    lit = ~lit;
    return lit[L-1:0];
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [3:0] s;
    logic       b;
    logic [2:0] md_old;
    int         ph_old, k;
    if (!rst) begin
      n = 0; epoch = 0; m_run = 0; m_phase = 0;
      m_cand = '0; m_db = '0; m_mode = '0;
      swh = {4'h0, 4'h0};
      bh  = {1'b0, 1'b0};
      exp_left = '1; exp_right = '1; exp_mode = '0; exp_tick = 1'b0;
    end else begin
      md_old = m_mode;
      ph_old = m_phase;
      n++;
      swh.push_back(bus.sw);
      s = swh.pop_front();
      bh.push_back(bus.brake);
      b = bh.pop_front();
      m_mode = decode(m_db);
      if (s == m_cand) begin
        if (m_run >= int'(DB) - 1) m_db = m_cand;
        m_run++;
      end else begin
        m_cand = s;
        m_run  = 0;
      end
      if (m_mode != md_old) epoch = n;
      k = (n - epoch) / int'(HP);
      case (m_mode)
        3'd2, 3'd3: m_phase = k % (int'(L) + 1);
        3'd4:       m_phase = k % 2;
        default:    m_phase = 0;
      endcase
      exp_tick = (((n - epoch) % int'(HP)) == int'(HP) - 1);
      exp_mode = m_mode;
      case (md_old)
        3'd2: begin exp_left = sweep_pat(ph_old); exp_right = b ? '0 : '1; end
        3'd3: begin exp_right = sweep_pat(ph_old); exp_left = b ? '0 : '1; end
        3'd4: begin exp_left = (ph_old == 0) ? '0 : '1; exp_right = exp_left; end
        default: begin exp_left = b ? '0 : '1; exp_right = exp_left; end
      endcase
    end
  end

  task automatic test_reset();
    bus.sw = 4'b0000;
    bus.brake = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {3'b111, 3'b111, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got l=%b r=%b m=%0d t=%b want l=111 r=111 m=0 t=0",
               bus.left_lamp, bus.right_lamp, bus.mode, bus.tick);
    end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    bus.sw = 4'b0000;
    bus.brake = 1'b0;
    repeat (3 * HP) begin
      @(negedge clk);
      checks++;
      if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {exp_left, exp_right, exp_mode, exp_tick}) begin
        errors++;
        $display("FAIL idle: got l=%b r=%b m=%0d t=%b want l=%b r=%b m=%0d t=%b",
                 bus.left_lamp, bus.right_lamp, bus.mode, bus.tick, exp_left, exp_right, exp_mode, exp_tick);
      end
    end
  endtask

  task automatic test_left_sweep();
    bus.sw = 4'b1000;
    bus.brake = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) bus.brake = ~bus.brake;
      checks++;
      if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {exp_left, exp_right, exp_mode, exp_tick}) begin
        errors++;
        $display("FAIL left_sweep: got l=%b r=%b m=%0d t=%b want l=%b r=%b m=%0d t=%b",
                 bus.left_lamp, bus.right_lamp, bus.mode, bus.tick, exp_left, exp_right, exp_mode, exp_tick);
      end
    end
    checks++;
    if (bus.mode !== 3'd2) begin
      errors++;
      $display("FAIL left_mode: got %0d want 2", bus.mode);
    end
  endtask

  task automatic test_hazard();
    bus.sw = 4'b1111;
    repeat (3) @(negedge clk);
    bus.brake = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) bus.brake = ~bus.brake;
      checks++;
      if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {exp_left, exp_right, exp_mode, exp_tick}) begin
        errors++;
        $display("FAIL hazard: got l=%b r=%b m=%0d t=%b want l=%b r=%b m=%0d t=%b",
                 bus.left_lamp, bus.right_lamp, bus.mode, bus.tick, exp_left, exp_right, exp_mode, exp_tick);
      end
    end
    checks++;
    if (bus.mode !== 3'd4) begin
      errors++;
      $display("FAIL hazard_mode: got %0d want 4", bus.mode);
    end
  endtask

  task automatic test_right_brake();
    bus.sw = 4'b0001;
    bus.brake = 1'b1;
    repeat (25 + 3) begin
      @(negedge clk);
      checks++;
      if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {exp_left, exp_right, exp_mode, exp_tick}) begin
        errors++;
        $display("FAIL right_brake: got l=%b r=%b m=%0d t=%b want l=%b r=%b m=%0d t=%b",
                 bus.left_lamp, bus.right_lamp, bus.mode, bus.tick, exp_left, exp_right, exp_mode, exp_tick);
      end
      if (n % 28 == 25) bus.brake = 1'b0;
    end
    bus.brake = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.left_lamp !== 3'b111) begin
      errors++;
      $display("FAIL brake_release: got l=%b want 111", bus.left_lamp);
    end
  endtask

  task automatic test_glitch();
    bus.sw = 4'b0000;
    bus.brake = 1'b0;
    repeat (10) @(negedge clk);
    bus.sw = 4'b0110;
    repeat (2) @(negedge clk);
    bus.sw = 4'b0000;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {exp_left, exp_right, exp_mode, exp_tick}) begin
        errors++;
        $display("FAIL glitch: got l=%b r=%b m=%0d t=%b want l=%b r=%b m=%0d t=%b",
                 bus.left_lamp, bus.right_lamp, bus.mode, bus.tick, exp_left, exp_right, exp_mode, exp_tick);
      end
    end
    checks++;
    if (bus.mode !== 3'd0) begin
      errors++;
      $display("FAIL glitch_mode: got %0d want 0", bus.mode);
    end
    bus.sw = 4'b0110;
    repeat (10) @(negedge clk);
    checks++;
    if ({bus.mode, bus.left_lamp, bus.right_lamp} !== {3'd1, 3'b111, 3'b111}) begin
      errors++;
      $display("FAIL straight: got m=%0d l=%b r=%b want m=1 l=111 r=111", bus.mode, bus.left_lamp, bus.right_lamp);
    end
  endtask

  task automatic test_midsweep_switch();
    bit found = 1'b0;
    bus.sw = 4'b1000;
    bus.brake = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (exp_mode == 3'd2 && m_phase == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midsweep_wait: phase 2 of left mode not reached within 200 cycles");
    end
    bus.sw = 4'b0001;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {exp_left, exp_right, exp_mode, exp_tick}) begin
        errors++;
        $display("FAIL midsweep: got l=%b r=%b m=%0d t=%b want l=%b r=%b m=%0d t=%b",
                 bus.left_lamp, bus.right_lamp, bus.mode, bus.tick, exp_left, exp_right, exp_mode, exp_tick);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.sw = 4'b1000;
    bus.brake = 1'b1;
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {3'b111, 3'b111, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got l=%b r=%b m=%0d t=%b want l=111 r=111 m=0 t=0",
               bus.left_lamp, bus.right_lamp, bus.mode, bus.tick);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (15) begin
      @(negedge clk);
      checks++;
      if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {exp_left, exp_right, exp_mode, exp_tick}) begin
        errors++;
        $display("FAIL after_reset: got l=%b r=%b m=%0d t=%b want l=%b r=%b m=%0d t=%b",
                 bus.left_lamp, bus.right_lamp, bus.mode, bus.tick, exp_left, exp_right, exp_mode, exp_tick);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] opts [7];
    opts = '{4'b0000, 4'b0110, 4'b1000, 4'b0001, 4'b1111, 4'b1010, 4'b0011};
    repeat (16) begin
      bus.sw = opts[$urandom_range(0, 6)];
      bus.brake = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 20)) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) bus.brake = ~bus.brake;
        checks++;
        if ({bus.left_lamp, bus.right_lamp, bus.mode, bus.tick} !== {exp_left, exp_right, exp_mode, exp_tick}) begin
          errors++;
          $display("FAIL random sw=%b: got l=%b r=%b m=%0d t=%b want l=%b r=%b m=%0d t=%b", bus.sw,
                   bus.left_lamp, bus.right_lamp, bus.mode, bus.tick, exp_left, exp_right, exp_mode, exp_tick);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_left_sweep();
    test_hazard();
    test_right_brake();
    test_glitch();
    test_midsweep_switch();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/car_signal_ctrl.md
Name: car_signal_ctrl

Overview:
- Parametrised successor to the single-pair car lamp controller: drives N lamps per side with a sequential-sweep turn indicator, unison hazard flash and a brake override.
- Inputs are synchronised and debounced internally, and the blink rate comes from an internal tick counter, so no external divided clock is needed.
- Sits between the board switches/brake button and the active-low LED pins; the mode code output feeds the board's 7-seg decoder.

Parameters:
- LAMPS, 3: lamps per side; must be >= 1.
- HALF_PERIOD, 6000000: clk cycles per sweep step (0.5 s at 12 MHz); must be >= 2.
- DB_CYCLES, 240000: cycles sw must be stable before acceptance (20 ms at 12 MHz); must be >= 1.

Ports:
- clk  input  1  system clock, 12 MHz on board.
- rst  input  1  asynchronous active-low reset.
- sw  input  4  mode switches: 0110 straight, 1000 left, 0001 right, 1111 hazard; any other value is idle.
- brake  input  1  brake request, active-high, asynchronous to clk.
- left_lamp  output  LAMPS  left lamps, active-low (0 = lit); bit 0 is innermost.
- right_lamp  output  LAMPS  right lamps, active-low; bit 0 is innermost.
- mode  output  3  current mode: 0 idle, 1 straight, 2 left, 3 right, 4 hazard.
- tick  output  1  one-cycle pulse on each step advance.

Behaviour:
- Reset (asynchronous, rst=0):
  - left_lamp and right_lamp all 1 (off); mode=0; tick=0.
  - Synchronisers, debounce counter, tick counter and phase are cleared; the debounced switch value is 0000.
  - Reset mid-blink takes effect immediately, with no completion of the current pattern.
- Input conditioning:
  - sw and brake each pass through a 2-flop synchroniser.
  - The synchronised sw is compared with a candidate register. On mismatch, the candidate is loaded and the stability counter is cleared. On match, the counter increments.
  - When the counter reaches DB_CYCLES-1, the candidate is copied to sw_db.
  - brake is synchronised only, not debounced.
- Mode register:
  - mode decodes sw_db and updates 1 cycle after sw_db changes.
  - A change in mode clears the tick counter and phase in the same cycle; the new pattern starts at phase 0.
  - An sw change that reverts before DB_CYCLES stable cycles is ignored.
- Tick generator:
  - The counter runs 0..HALF_PERIOD-1 and wraps to 0.
  - tick=1 in the cycle the counter equals HALF_PERIOD-1.
  - The counter runs in every mode.
- Phase:
  - Advances on tick, except in idle and straight, where it is held at 0.
  - Left and right: 0..LAMPS, wrapping from LAMPS to 0.
  - Hazard: 0..1, wrapping.
- Lamp pattern (registered, 1 cycle after mode/phase/brake_sync change):
  - Left mode, left side: at phase p < LAMPS, lamps 0..p are lit; at phase LAMPS, all are off.
  - Left mode, right side: all lit if brake_sync=1, else all off.
  - Right mode: mirror of left mode.
  - Hazard: both sides all lit at phase 0 and all off at phase 1. Brake is ignored; hazard has priority.
  - Idle or straight: both sides all lit if brake_sync=1, else all off.
- Simultaneous events:
  - If a mode change and a tick fall in the same cycle, the mode change wins: phase=0 and no advance.
  - Reset overrides everything.
- Widths:
  - Counter widths are clog2 of the relevant parameter, minimum 1.
  - No overflow is possible: all counters wrap or saturate at their bounds, and the debounce counter holds once sw_db is accepted.

Test Plan (LAMPS=3, HALF_PERIOD=4, DB_CYCLES=3 unless stated):
- Reset, then sw=0000, brake=0 -> lamps 3'b111/3'b111, mode=0, tick pulses every 4 cycles.
- sw=1000 held -> mode=2 within 2+3+1 cycles. left_lamp steps through 110, 100, 000, 111 and repeats, one step per tick; right_lamp stays 111.
- sw=1111 then brake=1 -> mode=4; both sides toggle between 000 and 111 each tick; brake has no effect.
- sw=0001, brake=1 -> right side sweeps 110, 100, 000, 111; left_lamp holds 000. Releasing brake gives left_lamp=111 within 3 cycles.
- sw glitches 0000->0110 for 2 cycles then back -> mode stays 0. Holding 0110 -> mode=1, with lamps 111 while brake=0.
- Mid-sweep at phase 2 in left mode, switch sw to 0001 -> after debounce, phase restarts at 0 and right_lamp=110. Asserting rst=0 during the sweep -> all outputs return to reset values immediately, with no clock edge needed.
